toeplitz_acc: RTL
=================

# toeplitz_acc

Downstream GF(2) accumulator for the Toeplitz extractor. Each cycle it takes STRIDE matrix columns from the gencol instances, which are concatenated by the top level, together with STRIDE raw input bits. It XORs every column whose data bit is 1 into an L-bit accumulator. After N/STRIDE beats it emits one L-bit hash word through a one-entry valid/ready output buffer, and it flags data underruns and output overflows.

## Interface
Parameters:
- N, 256: raw bits per block; must equal the N of the gencol instances feeding `cols`.
- L, 128: hash length and column height.
- STRIDE, 1: columns and data bits consumed per cycle; N % STRIDE == 0.
- BEATS, N/STRIDE: derived; beats per block.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- cols  in  STRIDE*L  column slice k at [k*L +: L] is matrix column beat*STRIDE+k.
- din  in  STRIDE  raw bits; din[k] selects column slice k.
- din_valid  in  1  din holds a valid beat this cycle.
- beat_first  out  1  high while beat == 0; marks the block boundary for the data source.
- hash  out  L  completed hash word.
- hash_valid  out  1  hash is held and waiting for the sink.
- hash_ready  in  1  sink accepts hash when hash_valid && hash_ready.
- err_underrun  out  1  one-cycle pulse when a block is discarded for missing data.
- err_overflow  out  1  one-cycle pulse when a completed hash is dropped because the buffer is full.
- blk_ok  out  16  count of hashes loaded into the buffer; saturates at 16'hFFFF.
- blk_drop  out  16  count of blocks discarded (underrun plus overflow); saturates.

## Operation
- beat counter: width clog2(BEATS), minimum 1. It advances by 1 every cycle after reset is released and wraps from BEATS-1 to 0.
- beat never stalls, because the gencol instances free-run. The top level guarantees that `cols` is aligned with beat. din_valid does not gate the counter.
- Per-beat contribution: c = XOR over k of (cols[k*L +: L] & {L{din[k]}}).
- beat == 0: acc <= c and bad <= !din_valid. The accumulator restarts with no separate clear cycle.
- 0 < beat < BEATS-1: acc <= acc ^ c and bad <= bad | !din_valid.
- beat == BEATS-1, the completion cycle: final = acc ^ c and fbad = bad | !din_valid.
  - fbad = 1: hash buffer untouched, err_underrun pulses, blk_drop increments.
  - fbad = 0 and the buffer is free (hash_valid == 0, or hash_ready == 1 this cycle): hash <= final, hash_valid <= 1, blk_ok increments.
  - fbad = 0 and the buffer is full (hash_valid && !hash_ready): final is dropped, the held hash is unchanged, err_overflow pulses, blk_drop increments.
- Non-completion cycle with hash_valid && hash_ready: hash_valid <= 0; hash keeps its last value.
- BEATS == 1: every cycle is both first and completion. Use c directly and ignore acc.
- Counters saturate and never wrap. If one cycle would increment both counters, that cannot happen by construction: each completion increments exactly one of them.
- Reset values (immediate on reset low): beat 0, acc 0, bad 0, hash 0, hash_valid 0, err_underrun 0, err_overflow 0, blk_ok 0, blk_drop 0. beat_first is 1 during reset, since it is derived from beat.
- Reset low mid-block aborts the partial block silently: no error pulse, no count. A held hash is lost.

## Timing
- Latency: hash_valid rises on the edge that ends the completion beat. The cycle after the last data beat shows the new hash.
- Throughput: one hash per BEATS cycles. The sink must accept within BEATS cycles of hash_valid rising to avoid an overflow.
- Back-to-back: completion with hash_valid && hash_ready replaces the word with no bubble, and hash_valid stays 1.
- err_underrun and err_overflow are registered. They are high for exactly the cycle after the completion beat, aligned with where hash_valid would have risen.
- After reset deassertion, the first edge processes beat 0. The data source must present beat 0 of the block in the first cycle out of reset.
- All outputs are registered except beat_first, which is decoded from the registered beat.

## Test plan
Parameters for scenarios 1-4: N=8, L=4, STRIDE=1, and column j = 4'(j).
1. din=1 on all 8 beats, din_valid=1, hash_ready=1 -> hash=4'b0000 (XOR of 0..7), hash_valid pulses one cycle, blk_ok=1.
2. din=1 only on beats 3 and 5, then din=1 only on beat 7 in the next block, hash_ready=1 -> hashes 4'b0110 then 4'b0111 at exactly 8-cycle spacing.
3. din_valid=0 on beat 4 -> no hash_valid, err_underrun pulses once, blk_drop=1. The next clean block produces a correct hash.
4. hash_ready=0 held across two completions -> the first hash is held unchanged, err_overflow pulses at the second completion, blk_drop=1. Raising hash_ready on the completion cycle gives a gapless replacement with no error.
5. Reset low at beat 5 with a hash held -> all outputs are 0 immediately and beat_first=1. The next block hashes from scratch with no error pulses.
6. N=256, L=128, STRIDE=4 with random din and random stalls on hash_ready -> every hash matches the GF(2) model of the gencol matrix, and blk_ok + blk_drop equals the number of completed blocks.

Source files
------------

// File: rtl/toeplitz_acc.sv
// GF(2) accumulator: XORs data-selected Toeplitz columns over BEATS beats into one L-bit hash word.
// Hash appears the cycle after the completion beat; a one-entry valid/ready buffer drops words when full.
module toeplitz_acc #(
  parameter int N      = 256,
  parameter int L      = 128,
  parameter int STRIDE = 1,
  parameter int BEATS  = N / STRIDE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [STRIDE*L-1:0] cols,
  input  logic [STRIDE-1:0]   din,
  input  logic                din_valid,
  output logic                beat_first,
  output logic [L-1:0]        hash,
  output logic                hash_valid,
  input  logic                hash_ready,
  output logic                err_underrun,
  output logic                err_overflow,
  output logic [15:0]         blk_ok,
  output logic [15:0]         blk_drop
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  logic [BW-1:0] beat;
  logic [L-1:0]  acc;
  logic          bad;
  logic [L-1:0]  contrib;
  logic [L-1:0]  fin;
  logic          fbad;
  logic          first;
  logic          last;
  logic          buf_free;

  always_comb begin
    contrib = '0;
    for (int k = 0; k < STRIDE; k++) begin
      contrib = contrib ^ (cols[k*L +: L] & {L{din[k]}});
    end
  end

  assign first      = (beat == '0);
  assign last       = (beat == LAST);
  assign beat_first = first;

  // Masking acc/bad on the first beat restarts the block without a clear
  // cycle, and also covers BEATS == 1 where first and last coincide.
  assign fin      = (first ? '0 : acc) ^ contrib;
  assign fbad     = (first ? 1'b0 : bad) | ~din_valid;
  assign buf_free = ~hash_valid | hash_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat <= '0;
      acc  <= '0;
      bad  <= 1'b0;
    end else begin
      beat <= last ? '0 : beat + BW'(1);
      acc  <= fin;
      bad  <= fbad;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hash         <= '0;
      hash_valid   <= 1'b0;
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
      blk_ok       <= '0;
      blk_drop     <= '0;
    end else begin
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
      if (last && !fbad && buf_free) begin
        hash       <= fin;
        hash_valid <= 1'b1;
        if (blk_ok != 16'hFFFF) blk_ok <= blk_ok + 16'd1;
      end else begin
        // A sink handshake still drains the buffer on a discarded completion.
        if (hash_valid && hash_ready) hash_valid <= 1'b0;
        if (last) begin
          if (fbad) err_underrun <= 1'b1;
          else      err_overflow <= 1'b1;
          if (blk_drop != 16'hFFFF) blk_drop <= blk_drop + 16'd1;
        end
      end
    end
  end

endmodule
